// File: rtl/top_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : top_mux_if
//  Brief    : Select/data bundle for top_mux, with driver and mux-side modports.
//  Revision : 1.0 - initial release
// ============================================================================
interface top_mux_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             select_i;
  logic [WIDTH-1:0] data_0_i;
  logic [WIDTH-1:0] data_1_i;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] data_q_o;
  logic             sel_q_o;
  logic             switch_o;
  logic [CNT_W-1:0] switch_cnt_o;

  modport master (
    output select_i, data_0_i, data_1_i,
    input  data_o, data_q_o, sel_q_o, switch_o, switch_cnt_o
  );

  modport slave (
    input  select_i, data_0_i, data_1_i,
    output data_o, data_q_o, sel_q_o, switch_o, switch_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/top_mux.sv
`default_nettype none
// ============================================================================
//  Module   : top_mux
//  Brief    : 2:1 combinational mux with a registered observation path and a
//             saturating select-toggle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module top_mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  top_mux_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] w_data;
  logic             w_toggle;
  logic             w_cnt_sat;

  logic [WIDTH-1:0] r_data_q;
  logic             r_sel_q;
  logic             r_switch;
  logic [CNT_W-1:0] r_switch_cnt;

  // Zero-latency path: must stay live while the registers are held in reset.
  assign w_data    = bus.select_i ? bus.data_1_i : bus.data_0_i;
  assign w_toggle  = (bus.select_i != r_sel_q);
  assign w_cnt_sat = (r_switch_cnt == C_CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data_q     <= '0;
      r_sel_q      <= 1'b0;
      r_switch     <= 1'b0;
      r_switch_cnt <= '0;
    end else begin
      r_data_q <= w_data;
      r_sel_q  <= bus.select_i;
      r_switch <= w_toggle;
      if (w_toggle && !w_cnt_sat) begin
        r_switch_cnt <= r_switch_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.data_o       = w_data;
  assign bus.data_q_o     = r_data_q;
  assign bus.sel_q_o      = r_sel_q;
  assign bus.switch_o     = r_switch;
  assign bus.switch_cnt_o = r_switch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_top_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_top_mux
//  Brief    : Randomized self-checking bench for top_mux (8-bit and 2-bit counters).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_top_mux;

  localparam int W_A = 1;
  localparam int C_A = 8;
  localparam int W_B = 4;
  localparam int C_B = 2;

  logic clk_i = 1'b0;
  logic rst_n_i;

  always #5 clk_i = ~clk_i;

  top_mux_if #(.WIDTH(W_A), .CNT_W(C_A)) bus_a ();
  top_mux_if #(.WIDTH(W_B), .CNT_W(C_B)) bus_b ();

  top_mux #(.WIDTH(W_A), .CNT_W(C_A)) u_dut_a (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_a.slave)
  );

  top_mux #(.WIDTH(W_B), .CNT_W(C_B)) u_dut_b (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: toggles are tallied as an unbounded integer and the
  // saturating limit is applied only when forming the expected count.
  int               m_toggles;
  logic             m_sel_q;
  logic             m_switch;
  logic [W_A-1:0]   m_dq_a;
  logic [W_B-1:0]   m_dq_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_cnt(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic drive(input logic sel, input logic [W_A-1:0] a0, input logic [W_A-1:0] a1,
                       input logic [W_B-1:0] b0, input logic [W_B-1:0] b1);
    bus_a.select_i = sel;  bus_b.select_i = sel;
    bus_a.data_0_i = a0;   bus_a.data_1_i = a1;
    bus_b.data_0_i = b0;   bus_b.data_1_i = b1;
  endtask

  task automatic check_mux(input string tag);
    chk({tag, " data_o_a"}, 32'(bus_a.data_o),
        32'(bus_a.select_i ? bus_a.data_1_i : bus_a.data_0_i));
    chk({tag, " data_o_b"}, 32'(bus_b.data_o),
        32'(bus_b.select_i ? bus_b.data_1_i : bus_b.data_0_i));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " data_q_a"}, 32'(bus_a.data_q_o), 32'(m_dq_a));
    chk({tag, " data_q_b"}, 32'(bus_b.data_q_o), 32'(m_dq_b));
    chk({tag, " sel_q"},    32'(bus_a.sel_q_o),  32'(m_sel_q));
    chk({tag, " sel_q_b"},  32'(bus_b.sel_q_o),  32'(m_sel_q));
    chk({tag, " switch"},   32'(bus_a.switch_o), 32'(m_switch));
    chk({tag, " switch_b"}, 32'(bus_b.switch_o), 32'(m_switch));
    chk({tag, " cnt_a"},    32'(bus_a.switch_cnt_o), 32'(sat_cnt(m_toggles, C_A)));
    chk({tag, " cnt_b"},    32'(bus_b.switch_cnt_o), 32'(sat_cnt(m_toggles, C_B)));
  endtask

  task automatic model_reset();
    m_toggles = 0;
    m_sel_q   = 1'b0;
    m_switch  = 1'b0;
    m_dq_a    = '0;
    m_dq_b    = '0;
  endtask

  // Advance one rising edge; inputs are stable here because they change on negedges.
  task automatic edge_step(input string tag);
    logic tgl;
    @(posedge clk_i);
    if (rst_n_i) begin
      tgl       = (bus_a.select_i != m_sel_q);
      m_switch  = tgl;
      if (tgl) m_toggles++;
      m_sel_q   = bus_a.select_i;
      m_dq_a    = bus_a.select_i ? bus_a.data_1_i : bus_a.data_0_i;
      m_dq_b    = bus_b.select_i ? bus_b.data_1_i : bus_b.data_0_i;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic drive_at_negedge(input logic sel, input logic [W_A-1:0] a1);
    @(negedge clk_i);
    drive(sel, W_A'($urandom), a1, W_B'($urandom), W_B'($urandom));
    #1;
    check_mux("neg");
  endtask

  initial begin
    int pulses;
    logic cur_sel;
    logic [3:0] pat;

    // Reset held: channel 0 selected, data_0 = 1, data_1 random.
    rst_n_i = 1'b0;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 4'h5, 4'hA);
    for (int i = 0; i < 10; i++) begin
      bus_a.data_1_i = W_A'($urandom);
      bus_b.data_1_i = W_B'($urandom);
      #50;
      chk("rst ch0 data_o", 32'(bus_a.data_o), 32'd1);
      check_mux("rst ch0");
      check_regs("rst hold");
    end

    // Still in reset: channel 1 tracks data_1 immediately, data_0 ignored.
    bus_a.select_i = 1'b1;
    bus_b.select_i = 1'b1;
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      bus_a.data_1_i = pat[3-i];
      bus_a.data_0_i = W_A'($urandom);
      bus_b.data_1_i = W_B'($urandom);
      #1;
      chk("ch1 data_o", 32'(bus_a.data_o), 32'(pat[3-i]));
      check_mux("ch1");
      #49;
    end

    // Release with select = 1: first edge counts as a toggle. Then data 1, 0.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 1'b1, 4'h3, 4'hC);
    rst_n_i = 1'b1;
    edge_step("first edge");
    chk("first edge cnt", 32'(bus_a.switch_cnt_o), 32'd1);
    chk("first edge data_q", 32'(bus_a.data_q_o), 32'd1);
    drive_at_negedge(1'b1, 1'b0);
    edge_step("reg path");
    chk("reg path data_q", 32'(bus_a.data_q_o), 32'd0);
    edge_step("reg hold");

    // Fresh reset, then 10 toggles spaced 50 cycles apart.
    @(negedge clk_i);
    rst_n_i = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    check_regs("reset2");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    pulses  = 0;
    cur_sel = 1'b0;
    for (int t = 0; t < 10; t++) begin
      cur_sel = ~cur_sel;
      for (int c = 0; c < 50; c++) begin
        drive_at_negedge(cur_sel, W_A'($urandom));
        edge_step("toggle");
        if (bus_a.switch_o) pulses++;
      end
    end
    chk("toggle pulses", 32'(pulses), 32'd10);
    chk("toggle cnt_a", 32'(bus_a.switch_cnt_o), 32'd10);
    chk("toggle cnt_b sat", 32'(bus_b.switch_cnt_o), 32'd3);

    // Fresh reset, 4 toggles, then async reset while the pulse is high.
    @(negedge clk_i);
    rst_n_i = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cur_sel = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cur_sel = ~cur_sel;
      for (int c = 0; c < 5; c++) begin
        drive_at_negedge(cur_sel, W_A'($urandom));
        edge_step("pre-async");
        if (t == 2 && c == 0) chk("sat after 3rd", 32'(bus_b.switch_cnt_o), 32'd3);
        if (t == 3 && c == 0) break;
      end
    end
    chk("pulse before async", 32'(bus_a.switch_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check_regs("async rst");
    bus_a.data_1_i = ~bus_a.data_1_i;
    bus_b.data_1_i = ~bus_b.data_1_i;
    #1;
    check_mux("async mux");
    edge_step("async hold");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Random traffic with occasional between-edge select glitches.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      drive(($urandom_range(0, 3) == 0) ? ~bus_a.select_i : bus_a.select_i,
            W_A'($urandom), W_A'($urandom), W_B'($urandom), W_B'($urandom));
      #1;
      check_mux("rand");
      if ($urandom_range(0, 3) == 0) begin
        bus_a.select_i = ~bus_a.select_i;
        bus_b.select_i = ~bus_b.select_i;
        #1;
        check_mux("glitch");
        bus_a.select_i = ~bus_a.select_i;
        bus_b.select_i = ~bus_b.select_i;
      end
      edge_step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
